// File: rtl/uart_tx.sv
// UART transmitter: start bit, UART_SIZE data bits LSB-first, optional parity, stop bit.
// Compile-time option UART_TX_TWO_STOP_EN adds the stop_bits2 input for two stop bits.
module uart_tx #(
  parameter int UART_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  output logic                 phase_accum_reset,
  input  logic [UART_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_enable,
  input  logic                 parity_type,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                 stop_bits2,
`endif
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TX
);

  localparam int CW = $clog2(UART_SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(UART_SIZE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state;
  logic [UART_SIZE-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 par_en;
  logic                 par_bit;
  logic                 tx_q;
  logic                 tick;
`ifdef UART_TX_TWO_STOP_EN
  logic                 stop2_q;
  logic                 stop_second;
`endif

  // A tick landing in the generator-restart cycle belongs to the old phase.
  assign tick     = baud_tick && !phase_accum_reset;
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign TX       = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      shreg             <= '0;
      bit_cnt           <= '0;
      par_en            <= 1'b0;
      par_bit           <= 1'b0;
      tx_q              <= 1'b1;
      tx_done           <= 1'b0;
      phase_accum_reset <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q           <= 1'b0;
      stop_second       <= 1'b0;
`endif
    end else begin
      phase_accum_reset <= 1'b0;
      tx_done           <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid) begin
            // Parity is computed from the whole word now, before shifting destroys it.
            shreg             <= tx_data;
            par_en            <= parity_enable;
            par_bit           <= parity_type ? ^tx_data : ~^tx_data;
            bit_cnt           <= '0;
            tx_q              <= 1'b0;
            phase_accum_reset <= 1'b1;
            state             <= START;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q           <= stop_bits2;
            stop_second       <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shreg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              tx_q  <= par_en ? par_bit : 1'b1;
              state <= par_en ? PARITY : STOP;
            end else begin
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            tx_q <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            if (stop2_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              state   <= IDLE;
            end
`else
            tx_done <= 1'b1;
            state   <= IDLE;
`endif
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a driver queues expected frames,
// a monitor collects the line value at each baud tick and compares at tx_done.
module tb_uart_tx;

  localparam int W   = 8;
  localparam int DIV = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         baud_tick;
  logic         phase_accum_reset;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         parity_enable = 1'b0;
  logic         parity_type = 1'b0;
  logic         stop_bits2 = 1'b0;
  logic         tx_busy;
  logic         tx_done;
  logic         tx;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad = 0;

  uart_tx #(.UART_SIZE(W)) dut (
    .clk(clk),
    .reset(reset),
    .baud_tick(baud_tick),
    .phase_accum_reset(phase_accum_reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
`ifdef UART_TX_TWO_STOP_EN
    .stop_bits2(stop_bits2),
`endif
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .TX(tx)
  );

  always #4 clk = ~clk;

  // Baud generator restarted by the DUT at each frame start.
  int bcnt = 0;
  always @(posedge clk) begin
    if (phase_accum_reset || bcnt == DIV - 1) bcnt <= 0;
    else bcnt <= bcnt + 1;
  end
  assign baud_tick = (bcnt == DIV - 1);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [W-1:0] d, input logic pe, input logic pt, input int nstop);
    frame_t f;
    int ones;
    f.bits = '0;
    f.len  = 0;
    f.len++;
    for (int i = 0; i < W; i++) begin
      f.bits[f.len] = d[i];
      f.len++;
    end
    if (pe) begin
      ones = $countones(d);
      f.bits[f.len] = pt ? logic'(ones % 2) : logic'(1 - ones % 2);
      f.len++;
    end
    for (int i = 0; i < nstop; i++) begin
      f.bits[f.len] = 1'b1;
      f.len++;
    end
    return f;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] d, input logic pe, input logic pt, input logic s2);
    int n = 0;
    int nstop = 1;
`ifdef UART_TX_TWO_STOP_EN
    if (s2) nstop = 2;
`endif
    tx_data       = d;
    parity_enable = pe;
    parity_type   = pt;
    stop_bits2    = s2;
    tx_valid      = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", n < 5000, 1);
    exp_q.push_back(make_frame(d, pe, pt, nstop));
    @(posedge clk);
    @(negedge clk);
    tx_data       = W'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    stop_bits2    = 1'($urandom);
    tx_valid      = 1'b0;
  endtask

  // Monitor: bits collected at each honoured tick are compared when tx_done pulses.
  logic [15:0] got = '0;
  int          glen = 0;
  int          pulses = 0;
  logic        prev_done = 1'b0;
  logic        prev_valid = 1'b0;
  frame_t      ef;

  always @(negedge clk) begin
    if (reset) begin
      got = '0; glen = 0; pulses = 0; prev_done = 1'b0; prev_valid = 1'b0;
    end else begin
      if (prev_done && prev_valid) checkOutput("gap_accept", phase_accum_reset, 1);
      if (phase_accum_reset) pulses++;
      if (baud_tick && tx_busy && !phase_accum_reset) begin
        if (glen < 16) got[glen] = tx;
        glen++;
        checkOutput("ready_low", tx_ready, 0);
      end
      if (tx_done) begin
        checkOutput("done_idle", {tx_ready, tx_busy, tx}, 3'b101);
        checkOutput("queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ef = exp_q.pop_front();
          checkOutput("frame_len", glen, ef.len);
          checkOutput("frame_bits", got, ef.bits);
          checkOutput("phase_pulses", pulses, 1);
        end
        got = '0; glen = 0; pulses = 0;
      end
      prev_done  = tx_done;
      prev_valid = tx_valid;
    end
  end

  initial begin
    int t;
    int n;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {tx, tx_ready, tx_busy, tx_done, phase_accum_reset}, 5'b11000);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_state", {tx, tx_ready, tx_busy, tx_done, phase_accum_reset}, 5'b11000);

    applyStimulus(8'h65, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h65, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h65, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);

    // Abort a frame during data bit 3.
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    t = 0;
    n = 0;
    while (t < 4 && n < 5000) begin
      @(negedge clk);
      if (baud_tick && tx_busy && !phase_accum_reset) t++;
      n++;
    end
    checkOutput("reach_bit3", t, 4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", {tx, tx_busy, tx_ready}, 3'b101);
    exp_q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h96, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3 * DIV)) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
